// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit-ISA MIPS-style core with an n-bit datapath and a single
// shared memory port using a req/ready handshake; control is an internal FSM.
module cpu_multicycle #(
   parameter int unsigned n    = 16,
   parameter int unsigned NREG = 8
) (
   input  logic         clk,
   input  logic         reset,
   output logic         mem_req,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [n-1:0] mem_rdata,
   output logic [n-1:0] pc,
   output logic         retire,
   output logic         halted
);

   localparam int unsigned RIW = 3;
   localparam int unsigned IW  = 16;

   localparam logic [2:0] OP_R    = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_J    = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd7;

   localparam logic [3:0] F_ADD = 4'd0;
   localparam logic [3:0] F_SUB = 4'd1;
   localparam logic [3:0] F_AND = 4'd2;
   localparam logic [3:0] F_OR  = 4'd3;
   localparam logic [3:0] F_SLT = 4'd4;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t          state_q,     state_d;
   logic [n-1:0]    pc_q,        pc_d;
   logic [IW-1:0]   ir_q,        ir_d;
   logic [n-1:0]    a_q,         a_d;
   logic [n-1:0]    b_q,         b_d;
   logic [n-1:0]    alu_q,       alu_d;
   logic [n-1:0]    mdr_q,       mdr_d;
   logic [n-1:0]    regs_q [NREG];
   logic [n-1:0]    regs_d [NREG];
   logic            mem_req_q,   mem_req_d;
   logic            mem_we_q,    mem_we_d;
   logic [n-1:0]    mem_addr_q,  mem_addr_d;
   logic [n-1:0]    mem_wdata_q, mem_wdata_d;
   logic            retire_q,    retire_d;
   logic            halted_q,    halted_d;

   // Instruction field decode from the latched IR
   logic [2:0]     op;
   logic [RIW-1:0] rs, rt, rd;
   logic [3:0]     funct;
   logic [n-1:0]   imm;
   logic [12:0]    jaddr;
   logic [n-1:0]   jtgt;

   assign op    = ir_q[15:13];
   assign rs    = ir_q[12:10];
   assign rt    = ir_q[9:7];
   assign rd    = ir_q[6:4];
   assign funct = ir_q[3:0];
   assign imm   = {{(n-7){ir_q[6]}}, ir_q[6:0]};
   assign jaddr = ir_q[12:0];

   // Jump keeps the upper PC bits only when the address is wider than the ISA field
   if (n == 16) begin : g_j16
      assign jtgt = n'({jaddr, 1'b0});
   end else begin : g_jwide
      assign jtgt = {pc_q[n-1:14], jaddr, 1'b0};
   end

   logic [n-1:0] ra, rb;
   assign ra = (rs == '0) ? '0 : regs_q[rs];
   assign rb = (rt == '0) ? '0 : regs_q[rt];

   logic [n-1:0] alu_res;
   always_comb begin
      alu_res = '0;
      case (op)
         OP_R: begin
            case (funct)
               F_ADD:   alu_res = a_q + b_q;
               F_SUB:   alu_res = a_q - b_q;
               F_AND:   alu_res = a_q & b_q;
               F_OR:    alu_res = a_q | b_q;
               F_SLT:   alu_res = n'($signed(a_q) < $signed(b_q));
               default: alu_res = '0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm;
         default:               alu_res = '0;
      endcase
   end

   logic           wb_en;
   logic [RIW-1:0] wb_idx;
   logic [n-1:0]   wb_val;
   assign wb_en  = ((op == OP_R) && (funct <= F_SLT)) || (op == OP_ADDI) || (op == OP_LW);
   assign wb_idx = (op == OP_R) ? rd : rt;
   assign wb_val = (op == OP_LW) ? mdr_q : alu_q;

   // Next-state, datapath updates and registered memory-port outputs
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      regs_d   = regs_q;
      retire_d = 1'b0;
      halted_d = halted_q;

      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata[IW-1:0];
               pc_d    = pc_q + n'(2);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = ra;
            b_d = rb;
            if (op == OP_HALT) begin
               state_d  = S_HALT;
               retire_d = 1'b1;
               halted_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_d = alu_res;
            case (op)
               OP_BEQ: begin
                  if (a_q == b_q) pc_d = pc_q + (imm << 1);
                  state_d  = S_FETCH;
                  retire_d = 1'b1;
               end
               OP_J: begin
                  pc_d     = jtgt;
                  state_d  = S_FETCH;
                  retire_d = 1'b1;
               end
               OP_LW, OP_SW:  state_d = S_MEM;
               OP_R, OP_ADDI: state_d = S_WB;
               default: begin
                  state_d  = S_FETCH;
                  retire_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (op == OP_SW) begin
                  state_d  = S_FETCH;
                  retire_d = 1'b1;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            if (wb_en && (wb_idx != '0)) regs_d[wb_idx] = wb_val;
            state_d  = S_FETCH;
            retire_d = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase

      mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we_d    = (state_d == S_MEM) && (op == OP_SW);
      mem_wdata_d = (state_d == S_MEM) ? b_q : '0;
      if (state_d == S_FETCH)    mem_addr_d = pc_d;
      else if (state_d == S_MEM) mem_addr_d = alu_d;
      else                       mem_addr_d = mem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
         mem_req_q   <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         retire_q    <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         alu_q       <= alu_d;
         mdr_q       <= mdr_d;
         regs_q      <= regs_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         retire_q    <= retire_d;
         halted_q    <= halted_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign pc        = pc_q;
   assign retire    = retire_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: word memory model behind the req/ready
// port, hand-computed register, PC, retire-timing and store expectations.
module tb_cpu_multicycle;

   localparam int unsigned N = 16;

   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [15:0] HALT   = 16'hE000;

   logic         clk;
   logic         reset;
   logic         mem_req, mem_we, mem_ready;
   logic [N-1:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic         retire, halted;

   logic         ready_en, hold_wr;
   logic [15:0]  mem [256];

   int           n_vec, n_err, cyc;
   int           rc [$];
   logic [N-1:0] rp [$];
   logic [N-1:0] wa [$];
   logic [N-1:0] wd [$];

   cpu_multicycle #(.n(N), .NREG(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .pc        (pc),
      .retire    (retire),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responds combinationally; hold_wr stalls only store accesses
   always_comb begin
      mem_ready = ready_en & ~(hold_wr & mem_we);
      mem_rdata = N'(mem[mem_addr[8:1]]);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ei(input logic [2:0] op, input int rs, input int rt, input int imm);
      return {op, 3'(rs), 3'(rt), 7'(imm)};
   endfunction

   function automatic logic [15:0] er(input int rs, input int rt, input int rd, input int f);
      return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(f)};
   endfunction

   function automatic logic [15:0] ej(input int a);
      return {3'b101, 13'(a)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
   endtask

   task automatic put(input int addr, input logic [15:0] w);
      mem[addr / 2] = w;
   endtask

   task automatic clear_logs();
      cyc = 0;
      rc.delete(); rp.delete(); wa.delete(); wd.delete();
   endtask

   // One clock: commit a completing store, advance, sample at the falling edge
   task automatic step();
      if (!reset && mem_req && mem_ready && mem_we) begin
         mem[mem_addr[8:1]] = mem_wdata[15:0];
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (retire) begin
         rc.push_back(cyc);
         rp.push_back(pc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic run_to_halt(input string tag);
      for (int i = 0; i < 300 && !halted; i++) step();
      chk({tag, "_halt"}, 32'(halted), 1);
   endtask

   task automatic chk_wr(input string tag, input int k, input logic [N-1:0] a, input logic [N-1:0] d);
      chk({tag, "_wr_present"}, 32'(wa.size() > k), 1);
      if (wa.size() > k) begin
         chk({tag, "_wr_addr"}, 32'(wa[k]), 32'(a));
         chk({tag, "_wr_data"}, 32'(wd[k]), 32'(d));
      end
   endtask

   task automatic chk_rc(input string tag, input int k, input int exp);
      chk(tag, (rc.size() > k) ? rc[k] : -1, exp);
   endtask

   task automatic load_t1();
      clear_mem();
      put(0, ei(OP_ADDI, 0, 1, 5));
      put(2, ei(OP_ADDI, 0, 2, -3));
      put(4, er(1, 2, 3, 0));
      put(6, ei(OP_SW, 0, 3, 32));
      put(8, HALT);
   endtask

   initial begin
      int t3c [6] = '{3, 8, 12, 17, 21, 23};
      int t4c [7] = '{4, 8, 11, 14, 17, 20, 23};
      int t4p [7] = '{2, 4, 'h80, 'h82, 6, 6, 6};
      int t5a [7] = '{50, 52, 54, 56, 58, 60, 62};
      int t5d [7] = '{0, 1, 9, 8, 5, 'hFFFD, 0};

      reset = 1'b1; ready_en = 1'b1; hold_wr = 1'b0;
      n_vec = 0; n_err = 0; cyc = 0;
      clear_mem();
      @(negedge clk);

      // addi/addi/add with zero-wait memory, then store r3 to observe it
      load_t1();
      do_reset();
      chk("rst_req",    32'(mem_req), 1);
      chk("rst_addr",   32'(mem_addr), 0);
      chk("rst_we",     32'(mem_we), 0);
      chk("rst_wdata",  32'(mem_wdata), 0);
      chk("rst_retire", 32'(retire), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_pc",     32'(pc), 0);
      repeat (12) step();
      chk("t1_nret", rc.size(), 3);
      for (int k = 0; k < 3; k++) chk_rc("t1_ret_cycle", k, 4 * (k + 1));
      run_to_halt("t1");
      chk_wr("t1_r3", 0, 16'd32, 16'd2);

      // First fetch stalled three cycles
      load_t1();
      ready_en = 1'b0;
      do_reset();
      chk("t2_addr0", 32'(mem_addr), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_req_held",  32'(mem_req), 1);
         chk("t2_addr_held", 32'(mem_addr), 0);
         chk("t2_pc_held",   32'(pc), 0);
      end
      ready_en = 1'b1;
      step();
      chk("t2_pc_after", 32'(pc), 2);
      chk("t2_req_drop", 32'(mem_req), 0);
      run_to_halt("t2");
      chk_rc("t2_first_ret", 0, 7);
      chk_wr("t2_r3", 0, 16'd32, 16'd2);

      // Jump into code at 0x20, store/load round trip through address 4
      clear_mem();
      put(0, ej('h10));
      put('h20, ei(OP_LW, 0, 1, 62));
      put('h22, ei(OP_SW, 0, 1, 4));
      put('h24, ei(OP_LW, 0, 4, 4));
      put('h26, ei(OP_SW, 0, 4, 6));
      put('h28, HALT);
      put(62, 16'h1234);
      do_reset();
      run_to_halt("t3");
      chk_wr("t3_sw_r1", 0, 16'd4, 16'h1234);
      chk_wr("t3_sw_r4", 1, 16'd6, 16'h1234);
      chk("t3_nret", rc.size(), 6);
      for (int k = 0; k < 6; k++) chk_rc("t3_ret_cycle", k, t3c[k]);

      // Branches and jumps; beq at 6 has byte offset -2 (imm7=-1) and spins
      clear_mem();
      put(0, ei(OP_ADDI, 0, 1, 5));
      put(2, ei(OP_ADDI, 0, 2, -3));
      put(4, ej('h40));
      put('h80, ei(OP_BEQ, 1, 2, 10));
      put('h82, ej(3));
      put(6, ei(OP_BEQ, 1, 1, -1));
      do_reset();
      repeat (23) step();
      chk("t4_nret", rc.size(), 7);
      for (int k = 0; k < 7; k++) begin
         chk_rc("t4_ret_cycle", k, t4c[k]);
         chk("t4_ret_pc", (rp.size() > k) ? 32'(rp[k]) : 32'hFFFF_FFFF, t4p[k]);
      end
      chk("t4_not_halted", 32'(halted), 0);

      // ALU functions, r0 discard, slt signed, undefined funct writes nothing
      clear_mem();
      put(0,  ei(OP_ADDI, 0, 1, 5));
      put(2,  ei(OP_ADDI, 0, 2, -3));
      put(4,  ei(OP_ADDI, 0, 6, 9));
      put(6,  er(1, 1, 0, 0));
      put(8,  er(2, 1, 5, 4));
      put(10, er(1, 1, 6, 7));
      put(12, er(1, 2, 3, 1));
      put(14, er(1, 2, 4, 2));
      put(16, ei(OP_SW, 0, 0, 50));
      put(18, ei(OP_SW, 0, 5, 52));
      put(20, ei(OP_SW, 0, 6, 54));
      put(22, ei(OP_SW, 0, 3, 56));
      put(24, ei(OP_SW, 0, 4, 58));
      put(26, er(1, 2, 4, 3));
      put(28, ei(OP_SW, 0, 4, 60));
      put(30, er(1, 2, 4, 4));
      put(32, ei(OP_SW, 0, 4, 62));
      put(34, HALT);
      do_reset();
      run_to_halt("t5");
      chk("t5_nwr", wa.size(), 7);
      for (int k = 0; k < 7; k++) chk_wr("t5", k, N'(t5a[k]), N'(t5d[k]));

      // Reset during a stalled store, then rerun to halt
      clear_mem();
      put(0, ei(OP_ADDI, 0, 1, 7));
      put(2, ei(OP_SW, 0, 1, 40));
      put(4, HALT);
      hold_wr = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && !mem_we; i++) step();
      chk("t6_in_mem", 32'(mem_we), 1);
      step();
      step();
      chk("t6_wait_addr", 32'(mem_addr), 40);
      chk("t6_wait_data", 32'(mem_wdata), 7);
      chk("t6_wait_req",  32'(mem_req), 1);
      chk("t6_no_wr",     wa.size(), 0);
      chk("t6_nret_pre",  rc.size(), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      hold_wr = 1'b0;
      chk("t6_rst_retire", 32'(retire), 0);
      chk("t6_rst_pc",     32'(pc), 0);
      chk("t6_rst_req",    32'(mem_req), 1);
      chk("t6_rst_addr",   32'(mem_addr), 0);
      chk("t6_rst_we",     32'(mem_we), 0);
      chk("t6_no_wr_rst",  wa.size(), 0);
      clear_logs();
      run_to_halt("t6");
      chk("t6_halt_retire", 32'(retire), 1);
      chk("t6_nwr", wa.size(), 1);
      chk_wr("t6_sw", 0, 16'd40, 16'd7);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_halt_req",    32'(mem_req), 0);
         chk("t6_halt_ret_lo", 32'(retire), 0);
         chk("t6_halt_stays",  32'(halted), 1);
      end
      chk("t6_halt_pc", 32'(pc), 6);
      chk("t6_nret", rc.size(), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
